// File: rtl/sap3_bus_pkg.sv
// Shared SAP3 bus definitions: FSM states, default bus widths and I/O bank addresses
// used by both the initiator and the responders.
package sap3_bus_pkg;

  localparam int SAP3_ADDR_WIDTH = 16;
  localparam int SAP3_DATA_WIDTH = 8;

  // Responders decode on these bases; each bank spans IO_BANK_SIZE addresses.
  localparam logic [SAP3_ADDR_WIDTH-1:0] IO_BANK0_BASE = 16'h0000;
  localparam logic [SAP3_ADDR_WIDTH-1:0] IO_BANK1_BASE = 16'h0010;
  localparam logic [SAP3_ADDR_WIDTH-1:0] IO_BANK2_BASE = 16'h0020;
  localparam logic [SAP3_ADDR_WIDTH-1:0] IO_BANK_SIZE  = 16'h0010;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } bus_state_t;

endpackage

// File: rtl/bus_initiator_if.sv
// Request/response handshake and bus control signals of the SAP3 initiator.
// bus_data stays a plain inout port on the initiator because it is tristated.
interface bus_initiator_if
  import sap3_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = SAP3_ADDR_WIDTH,
  parameter int DATA_WIDTH = SAP3_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_rd;
  logic                  bus_wr;
  logic                  bus_rdy;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, bus_rdy,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_rd, bus_wr
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, bus_rdy,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, bus_addr, bus_rd, bus_wr
  );

endinterface

// File: rtl/bus_data_driver.sv
// Tristate buffer for the shared data bus; the only driver of bus_data inside the initiator.
module bus_data_driver #(
  parameter int WIDTH = 8
) (
  input  logic             oe,
  input  logic [WIDTH-1:0] dout,
  inout  wire  [WIDTH-1:0] bus_data,
  output logic [WIDTH-1:0] din
);

  assign bus_data = oe ? dout : {WIDTH{1'bz}};
  assign din      = bus_data;

endmodule

// File: rtl/bus_initiator.sv
// SAP3 bus initiator: sequences SETUP -> STROBE (with wait states) -> HOLD for one request at a time.
// Optional strobe timeout is enabled by defining BUS_TIMEOUT_EN.
module bus_initiator
  import sap3_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = SAP3_ADDR_WIDTH,
  parameter int DATA_WIDTH     = SAP3_DATA_WIDTH,
  parameter int WAIT_STATES    = 0,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  bus_initiator_if.master       bif,
  inout  wire  [DATA_WIDTH-1:0] bus_data
);

  localparam int CW = $clog2(WAIT_STATES + 1) + 1;
  localparam logic [CW-1:0] WAIT_TARGET = CW'(WAIT_STATES);

  bus_state_t            state, state_next;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] din;
  logic                  err_q;
  logic [CW-1:0]         wait_cnt;
  logic                  accept;
  logic                  ready_exit;
  logic                  timeout;
  logic                  data_oe;

  assign accept     = (state == IDLE) && bif.req_valid;
  assign ready_exit = (state == STROBE) && (wait_cnt >= WAIT_TARGET) && bif.bus_rdy;

`ifdef BUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] strobe_cnt;

  // Counts strobe cycles; the FSM leaves STROBE no later than TIMEOUT_LAST, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      strobe_cnt <= '0;
    end else if (state == STROBE) begin
      strobe_cnt <= strobe_cnt + 1'b1;
    end else begin
      strobe_cnt <= '0;
    end
  end

  assign timeout = (state == STROBE) && (strobe_cnt == TIMEOUT_LAST) && !ready_exit;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SETUP;
      SETUP:   state_next = STROBE;
      STROBE:  if (ready_exit || timeout) state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, saturating wait counter and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (accept) begin
        we_q    <= bif.req_we;
        addr_q  <= bif.req_addr;
        wdata_q <= bif.req_wdata;
        err_q   <= 1'b0;
      end
      if (state == STROBE) begin
        if (wait_cnt != {CW{1'b1}}) wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (ready_exit && !we_q) begin
        rdata_q <= din;
      end else if (timeout) begin
        err_q <= 1'b1;
        if (!we_q) rdata_q <= '1;
      end
    end
  end

  // Write data is driven from SETUP through HOLD to give setup and hold time around the strobe.
  assign data_oe = we_q && (state != IDLE);

  assign bif.req_ready = (state == IDLE);
  assign bif.rsp_valid = (state == HOLD);
  assign bif.rsp_rdata = rdata_q;
  assign bif.rsp_err   = err_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_rd    = (state == STROBE) && !we_q;
  assign bif.bus_wr    = (state == STROBE) && we_q;

  bus_data_driver #(.WIDTH(DATA_WIDTH)) u_data_driver (
    .oe       (data_oe),
    .dout     (wdata_q),
    .bus_data (bus_data),
    .din      (din)
  );

endmodule

// File: tb/tb_bus_initiator.sv
// Directed testbench for bus_initiator: one instance with WAIT_STATES=0, one with WAIT_STATES=2.
// Pullups on each data bus make a released bus read back as all ones.
module tb_bus_initiator;

  logic       clk;
  logic       rst;
  logic [7:0] resp_val0;
  logic [7:0] resp_val2;
  wire  [7:0] bd0;
  wire  [7:0] bd2;

  int checks = 0;
  int errors = 0;

  bus_initiator_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) if0 ();
  bus_initiator_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) if2 ();

  bus_initiator #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(0), .TIMEOUT_CYCLES(8)) u_ws0 (
    .clk      (clk),
    .rst      (rst),
    .bif      (if0.master),
    .bus_data (bd0)
  );

  bus_initiator #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .WAIT_STATES(2), .TIMEOUT_CYCLES(8)) u_ws2 (
    .clk      (clk),
    .rst      (rst),
    .bif      (if2.master),
    .bus_data (bd2)
  );

  // Responders drive read data only while the read strobe is up.
  assign bd0 = if0.bus_rd ? resp_val0 : 8'bz;
  assign bd2 = if2.bus_rd ? resp_val2 : 8'bz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pullup (bd0[i]);
    pullup (bd2[i]);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int sel, input logic valid, input logic we,
                               input logic [15:0] addr, input logic [7:0] wdata);
    if (sel == 0) begin
      if0.req_valid = valid;
      if0.req_we    = we;
      if0.req_addr  = addr;
      if0.req_wdata = wdata;
    end else begin
      if2.req_valid = valid;
      if2.req_we    = we;
      if2.req_addr  = addr;
      if2.req_wdata = wdata;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int   rd_cnt;
    int   wr_cnt;
    int   lat;
    int   n_acc;
    int   n_rsp;
    int   acc_cyc [3];
    logic done;
    logic ready_before;

    rst = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    applyStimulus(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    if0.bus_rdy = 1'b1;
    if2.bus_rdy = 1'b1;
    resp_val0   = 8'h00;
    resp_val2   = 8'h00;
    acc_cyc     = '{0, 0, 0};

    #12;
    checkOutput("reset_req_ready", if0.req_ready, 1);
    checkOutput("reset_rsp_valid", if0.rsp_valid, 0);
    checkOutput("reset_rsp_rdata", if0.rsp_rdata, 0);
    checkOutput("reset_rsp_err",   if0.rsp_err,   0);
    checkOutput("reset_bus_addr",  if0.bus_addr,  0);
    checkOutput("reset_bus_rd",    if0.bus_rd,    0);
    checkOutput("reset_bus_wr",    if0.bus_wr,    0);
    checkOutput("reset_bus_data",  bd0,           8'hFF);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] write, WAIT_STATES=0");
    applyStimulus(0, 1'b1, 1'b1, 16'h0002, 8'hA5);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    checkOutput("wr_setup_ready", if0.req_ready, 0);
    checkOutput("wr_setup_addr",  if0.bus_addr,  16'h0002);
    checkOutput("wr_setup_wr",    if0.bus_wr,    0);
    checkOutput("wr_setup_data",  bd0,           8'hA5);
    tick();
    checkOutput("wr_strobe_wr",    if0.bus_wr,    1);
    checkOutput("wr_strobe_rd",    if0.bus_rd,    0);
    checkOutput("wr_strobe_valid", if0.rsp_valid, 0);
    tick();
    checkOutput("wr_hold_wr",    if0.bus_wr,    0);
    checkOutput("wr_hold_valid", if0.rsp_valid, 1);
    checkOutput("wr_hold_data",  bd0,           8'hA5);
    checkOutput("wr_hold_err",   if0.rsp_err,   0);
    tick();
    checkOutput("wr_idle_valid", if0.rsp_valid, 0);
    checkOutput("wr_idle_data",  bd0,           8'hFF);
    checkOutput("wr_idle_ready", if0.req_ready, 1);

    $display("[TB] read, WAIT_STATES=2");
    resp_val2 = 8'h3C;
    applyStimulus(2, 1'b1, 1'b0, 16'h0011, 8'h00);
    tick();
    applyStimulus(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    checkOutput("rd2_setup_rd",   if2.bus_rd, 0);
    checkOutput("rd2_setup_data", bd2,        8'hFF);
    rd_cnt = 0;
    lat    = 1;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      lat++;
      if (if2.bus_rd) rd_cnt++;
      if (if2.rsp_valid) done = 1'b1;
    end
    checkOutput("rd2_rsp_seen",  done,          1);
    checkOutput("rd2_rd_cycles", rd_cnt,        3);
    checkOutput("rd2_latency",   lat,           5);
    checkOutput("rd2_rdata",     if2.rsp_rdata, 8'h3C);
    tick();
    checkOutput("rd2_pulse_end", if2.rsp_valid, 0);

    $display("[TB] stretched read, WAIT_STATES=0");
    resp_val0   = 8'h5A;
    if0.bus_rdy = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 16'h0010, 8'h00);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    rd_cnt = 0;
    lat    = 1;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      lat++;
      if (if0.bus_rd) rd_cnt++;
      if (rd_cnt == 6) if0.bus_rdy = 1'b1;
      if (if0.rsp_valid) done = 1'b1;
    end
    checkOutput("st_rsp_seen",  done,          1);
    checkOutput("st_rd_cycles", rd_cnt,        6);
    checkOutput("st_latency",   lat,           8);
    checkOutput("st_rdata",     if0.rsp_rdata, 8'h5A);
    tick();

    $display("[TB] back-to-back writes");
    n_acc  = 0;
    n_rsp  = 0;
    wr_cnt = 0;
    applyStimulus(0, 1'b1, 1'b1, 16'h0020, 8'h11);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      ready_before = if0.req_ready;
      tick();
      if (if0.bus_wr) wr_cnt++;
      if (if0.rsp_valid) n_rsp++;
      if (ready_before && n_acc < 3) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 3) applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);
        else applyStimulus(0, 1'b1, 1'b1, 16'h0020 + 16'(n_acc), 8'h11 + 8'(n_acc));
      end
    end
    checkOutput("b2b_accepts",   n_acc,                  3);
    checkOutput("b2b_gap_1",     acc_cyc[1] - acc_cyc[0], 4);
    checkOutput("b2b_gap_2",     acc_cyc[2] - acc_cyc[1], 4);
    checkOutput("b2b_responses", n_rsp,                  3);
    checkOutput("b2b_wr_cycles", wr_cnt,                 3);
    checkOutput("b2b_last_addr", if0.bus_addr,           16'h0022);
    checkOutput("b2b_rdata_kept", if0.rsp_rdata,         8'h5A);

    $display("[TB] reset during write strobe");
    if0.bus_rdy = 1'b0;
    applyStimulus(0, 1'b1, 1'b1, 16'h0040, 8'hC3);
    tick();
    applyStimulus(0, 1'b0, 1'b0, 16'h0000, 8'h00);
    tick();
    checkOutput("rst_pre_wr",   if0.bus_wr, 1);
    checkOutput("rst_pre_data", bd0,        8'hC3);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rst_mid_wr",    if0.bus_wr,    0);
    checkOutput("rst_mid_data",  bd0,           8'hFF);
    checkOutput("rst_mid_ready", if0.req_ready, 1);
    checkOutput("rst_mid_valid", if0.rsp_valid, 0);
    checkOutput("rst_mid_rdata", if0.rsp_rdata, 0);
    #1;
    rst         = 1'b1;
    if0.bus_rdy = 1'b1;
    tick();
    checkOutput("rst_after_valid", if0.rsp_valid, 0);
    checkOutput("rst_after_ready", if0.req_ready, 1);

`ifdef BUS_TIMEOUT_EN
    $display("[TB] read timeout, TIMEOUT_CYCLES=8");
    if2.bus_rdy = 1'b0;
    applyStimulus(2, 1'b1, 1'b0, 16'h0012, 8'h00);
    tick();
    applyStimulus(2, 1'b0, 1'b0, 16'h0000, 8'h00);
    rd_cnt = 0;
    done   = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      tick();
      if (if2.bus_rd) rd_cnt++;
      if (if2.rsp_valid) done = 1'b1;
    end
    checkOutput("to_rsp_seen",  done,          1);
    checkOutput("to_rd_cycles", rd_cnt,        8);
    checkOutput("to_err",       if2.rsp_err,   1);
    checkOutput("to_rdata",     if2.rsp_rdata, 8'hFF);
    if2.bus_rdy = 1'b1;
    tick();
`else
    checkOutput("no_timeout_err", if0.rsp_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
